// File: rtl/port_io_pkg.sv
// port_io_pkg: default addresses and status-word bit positions for port_io_controller
package port_io_pkg;
    localparam logic [31:0] OUT_ADDR_DEF    = 32'h1001_0024;
    localparam logic [31:0] IN_ADDR_DEF     = 32'h1001_0028;
    localparam logic [31:0] STATUS_ADDR_DEF = 32'h1001_002C;
    localparam int ST_EMPTY     = 0;
    localparam int ST_FULL      = 1;
    localparam int ST_CHG       = 2;
    localparam int ST_OVF       = 3;
    localparam int ST_COUNT_LSB = 4;
endpackage

// File: rtl/port_io_if.sv
// port_io_if: processor data-bus access plus the PortIn/PortOut stream of the I/O block
interface port_io_if;
    logic [31:0] Address;
    logic [31:0] WriteData;
    logic        MemWrite;
    logic        MemRead;
    logic [31:0] ReadData;
    logic        Hit;
    logic [7:0]  PortIn;
    logic [31:0] PortOut;
    logic        PortOutValid;
    logic        PortOutReady;
    modport master (
        output Address, WriteData, MemWrite, MemRead, PortIn, PortOutReady,
        input  ReadData, Hit, PortOut, PortOutValid
    );
    modport slave (
        input  Address, WriteData, MemWrite, MemRead, PortIn, PortOutReady,
        output ReadData, Hit, PortOut, PortOutValid
    );
endinterface

// File: rtl/port_io_fifo.sv
// port_io_fifo: power-of-two FIFO; a push into a full FIFO is taken only alongside a pop
module port_io_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    localparam int PW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [PW:0]      count
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [PW:0]      count_q, count_d;
    logic             do_push, do_pop;
    assign empty   = count_q == '0;
    assign full    = count_q == (PW+1)'(DEPTH);
    assign count   = count_q;
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = empty ? '0 : mem_q[rd_ptr_q];
    always_comb begin
        mem_d = mem_q;
        if (do_push) mem_d[wr_ptr_q] = din;
        rd_ptr_d = rd_ptr_q + PW'(do_pop);
        wr_ptr_d = wr_ptr_q + PW'(do_push);
        count_d  = count_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
    end
    // Storage needs no reset: dout is forced to zero while the FIFO is empty.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end
endmodule

// File: rtl/port_io_controller.sv
// port_io_controller: memory-mapped PortOut FIFO / PortIn sampler; PORT_IO_SYNC_EN adds a two-flop input synchronizer
module port_io_controller
    import port_io_pkg::*;
#(
    parameter logic [31:0] OUT_ADDR    = OUT_ADDR_DEF,
    parameter logic [31:0] IN_ADDR     = IN_ADDR_DEF,
    parameter logic [31:0] STATUS_ADDR = STATUS_ADDR_DEF,
    parameter int          FIFO_DEPTH  = 4
) (
    input  logic      clk,
    input  logic      reset,
    port_io_if.slave  bus
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    logic          hit_out, hit_in, hit_st;
    logic          push, pop, full, empty;
    logic [CW-1:0] count;
    logic [7:0]    in_q, in_d;
    logic          chg_q, chg_d, ovf_q, ovf_d;
    logic [31:0]   status;
    assign hit_out = bus.Address == OUT_ADDR;
    assign hit_in  = bus.Address == IN_ADDR;
    assign hit_st  = bus.Address == STATUS_ADDR;
    assign push    = bus.MemWrite && hit_out;
    assign pop     = !empty && bus.PortOutReady;
    port_io_fifo #(.WIDTH(32), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (bus.WriteData),
        .dout  (bus.PortOut),
        .full  (full),
        .empty (empty),
        .count (count)
    );
    assign bus.PortOutValid = !empty;
`ifdef PORT_IO_SYNC_EN
    logic [7:0] meta_q, meta_d;
    assign meta_d = bus.PortIn;
    always_ff @(posedge clk) meta_q <= reset ? 8'h00 : meta_d;
    assign in_d = meta_q;
`else
    assign in_d = bus.PortIn;
`endif
    // Sets dominate the read-side clears when both land on the same edge.
    always_comb begin
        chg_d  = (in_d != in_q) || (chg_q && !(bus.MemRead && hit_in));
        ovf_d  = (push && full && !pop) || (ovf_q && !(bus.MemRead && hit_st));
        status = '0;
        status[ST_EMPTY] = empty;
        status[ST_FULL]  = full;
        status[ST_CHG]   = chg_q;
        status[ST_OVF]   = ovf_q;
        status[ST_COUNT_LSB +: CW] = count;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            in_q  <= '0;
            chg_q <= 1'b0;
            ovf_q <= 1'b0;
        end else begin
            in_q  <= in_d;
            chg_q <= chg_d;
            ovf_q <= ovf_d;
        end
    end
    assign bus.Hit      = hit_out || hit_in || hit_st;
    assign bus.ReadData = hit_in ? {24'b0, in_q} : hit_st ? status : 32'b0;
endmodule

// File: tb/tb_port_io_controller.sv
// tb_port_io_controller: directed and randomized checks of port_io_controller against a queue-based model
module tb_port_io_controller;
    localparam logic [31:0] OA = 32'h1001_0024;
    localparam logic [31:0] IA = 32'h1001_0028;
    localparam logic [31:0] SA = 32'h1001_002C;
    localparam int DEPTH = 4;
`ifdef PORT_IO_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;
    port_io_if bus();
    port_io_controller dut (.clk(clk), .reset(reset), .bus(bus));
    int checks = 0;
    int failures = 0;
    logic [31:0] mq[$];
    logic [7:0]  m_pipe[$];
    bit          m_ovf, m_chg;
    logic [7:0]  m_in;
    function automatic logic [31:0] m_status();
        return (32'(mq.size()) << 4) | {28'b0, m_ovf, m_chg, mq.size() == DEPTH, mq.size() == 0};
    endfunction
    function automatic logic [31:0] m_rdata(input logic [31:0] a);
        return a == IA ? {24'b0, m_in} : a == SA ? m_status() : 32'b0;
    endfunction
    task automatic drive(input logic [31:0] a, input logic [31:0] wd, input logic we, input logic re);
        bus.Address = a;
        bus.WriteData = wd;
        bus.MemWrite = we;
        bus.MemRead = re;
        #1;
    endtask
    task automatic tick();
        bit pop, push, rd_in, rd_st, ovf_set, rst;
        int n;
        logic [31:0] wd;
        logic [7:0] pin, nin;
        n = mq.size();
        rst = reset;
        pop = n > 0 && bus.PortOutReady;
        push = bus.MemWrite && bus.Address == OA;
        rd_in = bus.MemRead && bus.Address == IA;
        rd_st = bus.MemRead && bus.Address == SA;
        wd = bus.WriteData;
        pin = bus.PortIn;
        @(posedge clk);
        if (rst) begin
            mq.delete();
            m_pipe.delete();
            repeat (LAT - 1) m_pipe.push_back(8'h00);
            m_ovf = 0;
            m_chg = 0;
            m_in = 8'h00;
        end else begin
            ovf_set = 0;
            if (pop) void'(mq.pop_front());
            if (push) begin
                if (n < DEPTH || pop) mq.push_back(wd);
                else ovf_set = 1;
            end
            m_pipe.push_back(pin);
            nin = m_pipe.pop_front();
            if (nin != m_in) m_chg = 1;
            else if (rd_in) m_chg = 0;
            if (ovf_set) m_ovf = 1;
            else if (rd_st) m_ovf = 0;
            m_in = nin;
        end
        #1;
    endtask
    task automatic test_reset();
        reset = 1;
        tick();
        tick();
        reset = 0;
        drive(SA, 0, 0, 0);
        checks++; if (bus.PortOutValid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", bus.PortOutValid); end
        checks++; if (bus.PortOut !== 32'h0) begin failures++; $display("FAIL reset_portout got=%h exp=0", bus.PortOut); end
        checks++; if (bus.ReadData !== 32'h1) begin failures++; $display("FAIL reset_status got=%h exp=00000001", bus.ReadData); end
        checks++; if (bus.Hit !== 1'b1) begin failures++; $display("FAIL reset_hit got=%b exp=1", bus.Hit); end
    endtask
    task automatic test_single_store();
        bus.PortOutReady = 0;
        drive(OA, 32'hDEAD_BEEF, 1, 0);
        tick();
        drive(SA, 0, 0, 0);
        checks++; if (bus.PortOutValid !== 1'b1) begin failures++; $display("FAIL store_valid got=%b exp=1", bus.PortOutValid); end
        checks++; if (bus.PortOut !== 32'hDEAD_BEEF) begin failures++; $display("FAIL store_data got=%h exp=deadbeef", bus.PortOut); end
        checks++; if (bus.ReadData !== 32'h10) begin failures++; $display("FAIL store_status got=%h exp=00000010", bus.ReadData); end
        bus.PortOutReady = 1;
        tick();
        bus.PortOutReady = 0;
        checks++; if (bus.PortOutValid !== 1'b0) begin failures++; $display("FAIL store_pop_valid got=%b exp=0", bus.PortOutValid); end
    endtask
    task automatic test_overflow();
        bus.PortOutReady = 0;
        for (int i = 1; i <= 5; i++) begin
            drive(OA, 32'(i), 1, 0);
            tick();
        end
        drive(SA, 0, 0, 1);
        checks++; if (bus.ReadData !== 32'h4A) begin failures++; $display("FAIL ovf_status got=%h exp=0000004a", bus.ReadData); end
        tick();
        drive(SA, 0, 0, 0);
        checks++; if (bus.ReadData !== 32'h42) begin failures++; $display("FAIL ovf_clear got=%h exp=00000042", bus.ReadData); end
        bus.PortOutReady = 1;
        for (int i = 1; i <= 4; i++) begin
            checks++; if (bus.PortOutValid !== 1'b1 || bus.PortOut !== 32'(i)) begin failures++; $display("FAIL ovf_drain%0d got=%b/%h exp=1/%h", i, bus.PortOutValid, bus.PortOut, 32'(i)); end
            tick();
        end
        bus.PortOutReady = 0;
        checks++; if (bus.PortOutValid !== 1'b0) begin failures++; $display("FAIL ovf_drained got=%b exp=0", bus.PortOutValid); end
    endtask
    task automatic test_full_push_pop();
        logic [31:0] e[4] = '{32'd6, 32'd7, 32'd8, 32'd9};
        bus.PortOutReady = 0;
        for (int i = 5; i <= 8; i++) begin
            drive(OA, 32'(i), 1, 0);
            tick();
        end
        bus.PortOutReady = 1;
        drive(OA, 32'd9, 1, 0);
        tick();
        bus.PortOutReady = 0;
        drive(SA, 0, 0, 0);
        checks++; if (bus.ReadData !== 32'h42) begin failures++; $display("FAIL fpp_status got=%h exp=00000042", bus.ReadData); end
        bus.PortOutReady = 1;
        for (int i = 0; i < 4; i++) begin
            checks++; if (bus.PortOutValid !== 1'b1 || bus.PortOut !== e[i]) begin failures++; $display("FAIL fpp_drain%0d got=%b/%h exp=1/%h", i, bus.PortOutValid, bus.PortOut, e[i]); end
            tick();
        end
        bus.PortOutReady = 0;
        checks++; if (bus.PortOutValid !== 1'b0) begin failures++; $display("FAIL fpp_drained got=%b exp=0", bus.PortOutValid); end
    endtask
    task automatic test_input_change();
        bus.PortIn = 8'h00;
        drive(IA, 0, 0, 1);
        repeat (LAT + 1) tick();
        bus.PortIn = 8'hA5;
        drive(IA, 0, 0, 0);
        for (int i = 0; i < LAT - 1; i++) begin
            tick();
            checks++; if (bus.ReadData !== 32'h0) begin failures++; $display("FAIL in_early got=%h exp=0", bus.ReadData); end
        end
        tick();
        checks++; if (bus.ReadData !== 32'hA5) begin failures++; $display("FAIL in_value got=%h exp=000000a5", bus.ReadData); end
        drive(SA, 0, 0, 0);
        checks++; if (bus.ReadData[2] !== 1'b1) begin failures++; $display("FAIL in_chg_set got=%b exp=1", bus.ReadData[2]); end
        drive(IA, 0, 0, 1);
        tick();
        drive(SA, 0, 0, 0);
        checks++; if (bus.ReadData[2] !== 1'b0) begin failures++; $display("FAIL in_chg_clear got=%b exp=0", bus.ReadData[2]); end
        bus.PortIn = 8'h5A;
        drive(SA, 0, 0, 0);
        repeat (LAT - 1) tick();
        drive(IA, 0, 0, 1);
        tick();
        drive(SA, 0, 0, 0);
        checks++; if (bus.ReadData[2] !== 1'b1) begin failures++; $display("FAIL in_chg_setwins got=%b exp=1", bus.ReadData[2]); end
        drive(IA, 0, 0, 0);
        checks++; if (bus.ReadData !== 32'h5A) begin failures++; $display("FAIL in_value2 got=%h exp=0000005a", bus.ReadData); end
    endtask
    task automatic test_mid_reset();
        bus.PortOutReady = 0;
        for (int i = 0; i < 3; i++) begin
            drive(OA, $urandom, 1, 0);
            tick();
        end
        bus.PortOutReady = 1;
        reset = 1;
        drive(OA, $urandom, 1, 0);
        tick();
        reset = 0;
        drive(SA, 0, 0, 0);
        checks++; if (bus.PortOutValid !== 1'b0) begin failures++; $display("FAIL mrst_valid got=%b exp=0", bus.PortOutValid); end
        checks++; if (bus.ReadData !== 32'h1) begin failures++; $display("FAIL mrst_status got=%h exp=00000001", bus.ReadData); end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (bus.PortOutValid !== 1'b0 || bus.PortOut !== 32'h0) begin failures++; $display("FAIL mrst_idle%0d got=%b/%h exp=0/0", i, bus.PortOutValid, bus.PortOut); end
        end
        bus.PortOutReady = 0;
    endtask
    task automatic test_random();
        logic [31:0] a;
        int r;
        for (int i = 0; i < 600; i++) begin
            r = $urandom_range(0, 9);
            a = r < 4 ? OA : r < 6 ? IA : r < 8 ? SA : (r == 8 ? OA + 32'd4 : 32'($urandom));
            bus.PortOutReady = ((i / 60) % 2 == 1) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 3) == 0) bus.PortIn = 8'($urandom);
            reset = $urandom_range(0, 99) == 0;
            drive(a, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            checks++; if (bus.PortOutValid !== (mq.size() > 0)) begin failures++; $display("FAIL rnd_valid cyc=%0d got=%b exp=%b", i, bus.PortOutValid, mq.size() > 0); end
            checks++; if (bus.PortOut !== (mq.size() > 0 ? mq[0] : 32'h0)) begin failures++; $display("FAIL rnd_portout cyc=%0d got=%h exp=%h", i, bus.PortOut, mq.size() > 0 ? mq[0] : 32'h0); end
            checks++; if (bus.Hit !== (a == OA || a == IA || a == SA)) begin failures++; $display("FAIL rnd_hit cyc=%0d got=%b addr=%h", i, bus.Hit, a); end
            checks++; if (bus.ReadData !== m_rdata(a)) begin failures++; $display("FAIL rnd_rdata cyc=%0d got=%h exp=%h addr=%h", i, bus.ReadData, m_rdata(a), a); end
            tick();
        end
        reset = 0;
    endtask
    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end
    initial begin
        bus.PortOutReady = 0;
        bus.PortIn = 8'h00;
        drive(SA, 0, 0, 0);
        test_reset();
        test_single_store();
        test_overflow();
        test_full_push_pop();
        test_input_change();
        test_mid_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
